// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU control codes, MIPS opcode/funct constants and the issue-beat record.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD     = 4'b0000,
    ALU_SUB     = 4'b0001,
    ALU_AND     = 4'b0010,
    ALU_OR      = 4'b0011,
    ALU_SLL     = 4'b0100,
    ALU_SRL     = 4'b0101,
    ALU_SRA     = 4'b0110,
    ALU_GREATER = 4'b0111,
    ALU_LESS    = 4'b1000,
    ALU_NOR     = 4'b1001
  } alu_ctrl_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef struct packed {
    alu_ctrl_e   alu_control;
    logic [4:0]  shift_amount;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [4:0]  dest_reg;
    logic        reg_write;
    logic        illegal;
  } issue_beat_t;

endpackage

// File: rtl/mips_alu_decode.sv
// rtl/mips_alu_decode.sv - Combinational MIPS instruction to ALU issue-beat decoder.
module mips_alu_decode
  import alu_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output issue_beat_t beat_o
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [4:0]  shamt;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        legal;
  logic        writes;
  issue_beat_t b;
  logic        unused_rs_idx;

  assign opcode   = instr[31:26];
  assign rt_idx   = instr[20:16];
  assign rd_idx   = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'b0, instr[15:0]};
  // rs is consumed through rs_data; the index itself is not needed here.
  assign unused_rs_idx = ^instr[25:21];

  always_comb begin
    b             = '0;
    b.alu_control = ALU_ADD;
    legal         = 1'b1;
    writes        = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        b.data1    = rs_data;
        b.data2    = rt_data;
        b.dest_reg = rd_idx;
        case (funct)
          FN_ADD, FN_ADDU: b.alu_control = ALU_ADD;
          FN_SUB, FN_SUBU: b.alu_control = ALU_SUB;
          FN_AND:          b.alu_control = ALU_AND;
          FN_OR:           b.alu_control = ALU_OR;
          FN_NOR:          b.alu_control = ALU_NOR;
          FN_SLT:          b.alu_control = ALU_LESS;
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: begin
            // The ALU shifts its first operand, so rt moves to data1.
            b.data1        = rt_data;
            b.data2        = '0;
            b.shift_amount = funct[2] ? rs_data[4:0] : shamt;
            case (funct[1:0])
              2'b00:   b.alu_control = ALU_SLL;
              2'b10:   b.alu_control = ALU_SRL;
              default: b.alu_control = ALU_SRA;
            endcase
          end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
        b.data1    = rs_data;
        b.data2    = imm_sext;
        b.dest_reg = rt_idx;
        writes     = (opcode != OP_SW);
      end
      OP_SLTI: begin
        b.alu_control = ALU_LESS;
        b.data1       = rs_data;
        b.data2       = imm_sext;
        b.dest_reg    = rt_idx;
      end
      OP_ANDI, OP_ORI: begin
        b.alu_control = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
        b.data1       = rs_data;
        b.data2       = imm_zext;
        b.dest_reg    = rt_idx;
      end
      OP_BEQ, OP_BNE: begin
        b.alu_control = ALU_SUB;
        b.data1       = rs_data;
        b.data2       = rt_data;
        b.dest_reg    = rt_idx;
        writes        = 1'b0;
      end
      OP_LUI: begin
        b.alu_control  = ALU_SLL;
        b.data1        = imm_zext;
        b.shift_amount = 5'd16;
        b.dest_reg     = rt_idx;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      b             = '0;
      b.alu_control = ALU_ADD;
      b.illegal     = 1'b1;
      writes        = 1'b0;
    end
    b.reg_write = writes && (b.dest_reg != 5'd0);
    beat_o      = b;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID/EX issue stage: decode, registered output beat and one-entry skid buffer.
module alu_issue_stage
  import alu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_control,
  output logic [4:0]  shift_amount,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic [4:0]  dest_reg,
  output logic        reg_write,
  output logic        illegal
);

  issue_beat_t dec_beat;
  issue_beat_t out_q, out_d;
  issue_beat_t skid_q, skid_d;
  logic        out_valid_q, out_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        in_ready_q, in_ready_d;
  logic        accept;
  logic        out_free;

  mips_alu_decode u_decode (
    .instr   (instr),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .beat_o  (dec_beat)
  );

  // in_ready_q mirrors !skid_valid_q, so an accepted beat never meets a full skid.
  assign accept   = in_valid && in_ready_q && !flush;
  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = dec_beat;
      end
    end else if (accept) begin
      skid_d       = dec_beat;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign alu_control  = out_q.alu_control;
  assign shift_amount = out_q.shift_amount;
  assign data1        = out_q.data1;
  assign data2        = out_q.data2;
  assign dest_reg     = out_q.dest_reg;
  assign reg_write    = out_q.reg_write;
  assign illegal      = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - Directed table-driven bench for alu_issue_stage.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_control;
  logic [4:0]  shift_amount;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [4:0]  dest_reg;
  logic        reg_write;
  logic        illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr        (instr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .alu_control  (alu_control),
    .shift_amount (shift_amount),
    .data1        (data1),
    .data2        (data2),
    .dest_reg     (dest_reg),
    .reg_write    (reg_write),
    .illegal      (illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [3:0]  alu;
    logic [4:0]  sh;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  dest;
    logic        rw;
    logic        ill;
    logic        chk_dest;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_beat(input string nm, input vec_t v);
    chk({nm, ".out_valid"}, {31'b0, out_valid}, 32'd1);
    chk({nm, ".alu_control"}, {28'b0, alu_control}, {28'b0, v.alu});
    chk({nm, ".shift_amount"}, {27'b0, shift_amount}, {27'b0, v.sh});
    chk({nm, ".data1"}, data1, v.d1);
    chk({nm, ".data2"}, data2, v.d2);
    if (v.chk_dest) chk({nm, ".dest_reg"}, {27'b0, dest_reg}, {27'b0, v.dest});
    chk({nm, ".reg_write"}, {31'b0, reg_write}, {31'b0, v.rw});
    chk({nm, ".illegal"}, {31'b0, illegal}, {31'b0, v.ill});
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({nm, ".alu_control"}, {28'b0, alu_control}, 32'd0);
    chk({nm, ".shift_amount"}, {27'b0, shift_amount}, 32'd0);
    chk({nm, ".data1"}, data1, 32'd0);
    chk({nm, ".data2"}, data2, 32'd0);
    chk({nm, ".dest_reg"}, {27'b0, dest_reg}, 32'd0);
    chk({nm, ".reg_write"}, {31'b0, reg_write}, 32'd0);
    chk({nm, ".illegal"}, {31'b0, illegal}, 32'd0);
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    in_valid = v;
    instr    = i;
    rs_data  = rs;
    rt_data  = rt;
  endtask

  initial begin
    int   rx[$];
    int   sent;
    logic prev_stall;
    logic [31:0] prev_d2;
    logic ordy_pat[7];
    logic ir_exp[7];

    //                instr         rs            rt            alu    sh     d1            d2            dest   rw  ill chkd
    vecs[0]  = '{32'h2109FFFB, 32'd10,       32'd0,        4'b0000, 5'd0,  32'd10,       32'hFFFFFFFB, 5'd9,  1, 0, 1};
    vecs[1]  = '{32'h00095103, 32'd0,        32'h80000000, 4'b0110, 5'd4,  32'h80000000, 32'd0,        5'd10, 1, 0, 1};
    vecs[2]  = '{32'h3C081234, 32'd0,        32'd0,        4'b0100, 5'd16, 32'h00001234, 32'd0,        5'd8,  1, 0, 1};
    vecs[3]  = '{32'h35080001, 32'h12340000, 32'd0,        4'b0011, 5'd0,  32'h12340000, 32'h00000001, 5'd8,  1, 0, 1};
    vecs[4]  = '{32'h00221820, 32'd5,        32'd7,        4'b0000, 5'd0,  32'd5,        32'd7,        5'd3,  1, 0, 1};
    vecs[5]  = '{32'h00220022, 32'd9,        32'd4,        4'b0001, 5'd0,  32'd9,        32'd4,        5'd0,  0, 0, 1};
    vecs[6]  = '{32'h00222004, 32'h00000023, 32'h000000F0, 4'b0100, 5'd3,  32'h000000F0, 32'd0,        5'd4,  1, 0, 1};
    vecs[7]  = '{32'h28228000, 32'd3,        32'd0,        4'b1000, 5'd0,  32'd3,        32'hFFFF8000, 5'd2,  1, 0, 1};
    vecs[8]  = '{32'h30228000, 32'hFFFFFFFF, 32'd0,        4'b0010, 5'd0,  32'hFFFFFFFF, 32'h00008000, 5'd2,  1, 0, 1};
    vecs[9]  = '{32'hAC22FFFC, 32'd100,      32'd55,       4'b0000, 5'd0,  32'd100,      32'hFFFFFFFC, 5'd0,  0, 0, 0};
    vecs[10] = '{32'h10220003, 32'd11,       32'd12,       4'b0001, 5'd0,  32'd11,       32'd12,       5'd0,  0, 0, 0};
    vecs[11] = '{32'hFC000000, 32'd5,        32'd6,        4'b0000, 5'd0,  32'd0,        32'd0,        5'd0,  0, 1, 0};
    vecs[12] = '{32'h00221801, 32'd5,        32'd6,        4'b0000, 5'd0,  32'd0,        32'd0,        5'd0,  0, 1, 0};
    vecs[13] = '{32'h00222FC2, 32'd0,        32'hFFFFFFFF, 4'b0101, 5'd31, 32'hFFFFFFFF, 32'd0,        5'd5,  1, 0, 1};
    vecs[14] = '{32'h8C220010, 32'h00001000, 32'd0,        4'b0000, 5'd0,  32'h00001000, 32'h00000010, 5'd2,  1, 0, 1};
    vecs[15] = '{32'h00221827, 32'h0F0F0F0F, 32'h00FF00FF, 4'b1001, 5'd0,  32'h0F0F0F0F, 32'h00FF00FF, 5'd3,  1, 0, 1};
    vecs[16] = '{32'h0022182A, 32'hFFFFFFFE, 32'd1,        4'b1000, 5'd0,  32'hFFFFFFFE, 32'd1,        5'd3,  1, 0, 1};

    ordy_pat = '{1, 1, 0, 0, 1, 1, 1};
    ir_exp   = '{1, 1, 1, 0, 0, 1, 1};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk("reset.in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset.in_ready", {31'b0, in_ready}, 32'd1);
    chk("post_reset.out_valid", {31'b0, out_valid}, 32'd0);

    // Back-to-back issue with out_ready high: one-cycle latency, in_ready never drops.
    for (int i = 0; i <= NV; i++) begin
      if (i > 0) chk_beat($sformatf("vec%0d", i - 1), vecs[i - 1]);
      chk($sformatf("vec%0d.in_ready", i), {31'b0, in_ready}, 32'd1);
      if (i < NV) drive(1'b1, vecs[i].instr, vecs[i].rs, vecs[i].rt);
      else        drive(1'b0, 32'd0, 32'd0, 32'd0);
      @(negedge clk);
    end
    chk("drain.out_valid", {31'b0, out_valid}, 32'd0);

    // Four-beat stream with a two-cycle EX stall; data2 carries the beat tag.
    sent = 0;
    prev_stall = 1'b0;
    prev_d2 = '0;
    for (int k = 0; k < 12; k++) begin
      out_ready = (k < 7) ? ordy_pat[k] : 1'b1;
      if (k < 7) chk($sformatf("stall.in_ready.k%0d", k), {31'b0, in_ready}, {31'b0, ir_exp[k]});
      if (prev_stall) begin
        chk($sformatf("stall.frozen_valid.k%0d", k), {31'b0, out_valid}, 32'd1);
        chk($sformatf("stall.frozen_data.k%0d", k), data2, prev_d2);
      end
      if (out_valid && out_ready) rx.push_back(int'(data2));
      prev_stall = out_valid && !out_ready;
      prev_d2    = data2;
      if (sent < 4) drive(1'b1, 32'h21090000 | (sent + 1), 32'd0, 32'd0);
      else          drive(1'b0, 32'd0, 32'd0, 32'd0);
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    chk("stall.rx_count", rx.size(), 32'd4);
    for (int j = 0; j < 4; j++)
      if (j < rx.size()) chk($sformatf("stall.order%0d", j), rx[j], j + 1);

    // Flush with output and skid both full and a beat offered.
    out_ready = 1'b0;
    drive(1'b1, 32'h21090011, 32'd0, 32'd0);
    @(negedge clk);
    drive(1'b1, 32'h21090012, 32'd0, 32'd0);
    @(negedge clk);
    chk("flush.pre_in_ready", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 32'h21090013, 32'd0, 32'd0);
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    chk("flush.out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush.in_ready", {31'b0, in_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("flush.quiet%0d", k), {31'b0, out_valid}, 32'd0);
    end

    // Flush on an empty stage discards the beat offered with it.
    flush = 1'b1;
    drive(1'b1, 32'h21090014, 32'd0, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    chk("flush_empty.out_valid", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of a stall with the skid full.
    out_ready = 1'b0;
    drive(1'b1, vecs[0].instr, vecs[0].rs, vecs[0].rt);
    @(negedge clk);
    drive(1'b1, vecs[1].instr, vecs[1].rs, vecs[1].rt);
    @(negedge clk);
    chk("rst_stall.pre_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk_all_zero("rst_stall");
    chk("rst_stall.in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_stall.after_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_stall.after_out_valid", {31'b0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX issue stage that produces the ALU's operand and control stream: it accepts a MIPS instruction word plus register-file read data, decodes the 4-bit ALU control code, the shift amount and both operands, and presents them to the 32-bit ALU through a registered valid/ready interface. A one-entry skid buffer absorbs EX-side stalls without dropping instructions. A flush input squashes in-flight entries on branch redirect.

## Interface
- No parameters; data width fixed at 32, register index at 5.
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  squash all held entries (branch redirect)
- in_valid  in  1  instruction beat offered
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- instr  in  32  MIPS instruction word
- rs_data  in  32  register rs read value
- rt_data  in  32  register rt read value
- out_valid  out  1  issue beat valid
- out_ready  in  1  EX stage accepts beat
- alu_control  out  4  ADD=0000 SUB=0001 AND=0010 OR=0011 SLL=0100 SRL=0101 SRA=0110 GREATER=0111 LESS=1000 NOR=1001
- shift_amount  out  5  shift count for ALU
- data1, data2  out  32  ALU operands, signed
- dest_reg  out  5  writeback index
- reg_write  out  1  writeback enable (forced 0 when dest_reg==0)
- illegal  out  1  beat carries an undecodable instruction

## Operation
- R-type (opcode 0x00), data1=rs, data2=rt, dest=rd unless noted: funct 0x20/0x21 ADD; 0x22/0x23 SUB; 0x24 AND; 0x25 OR; 0x27 NOR; 0x2A LESS.
- Shifts: 0x00 SLL, 0x02 SRL, 0x03 SRA with shift_amount=instr[10:6]; 0x04/0x06/0x07 same ops with shift_amount=rs_data[4:0]. For all shifts data1=rt_data (ALU shifts data1), data2=0.
- I-type, dest=rt, data1=rs: 0x08/0x09 ADD sign-ext imm; 0x0A LESS sign-ext; 0x0C AND zero-ext; 0x0D OR zero-ext; 0x23 lw ADD sign-ext.
- 0x2B sw: ADD sign-ext, reg_write=0. 0x04/0x05 beq/bne: SUB, data2=rt_data, reg_write=0.
- 0x0F lui: SLL, data1=zero-ext imm, shift_amount=16, dest=rt.
- Non-shift ops drive shift_amount=0.
- Any other opcode/funct: alu_control=ADD, data1=data2=0, reg_write=0, illegal=1; beat still issued (exception logic downstream).
- Buffering: main output register + one skid register. Accept when in_valid && in_ready. If output empty or out_ready, load output (from skid first if skid_valid, else from input); otherwise input goes to skid.
- Outputs stable while out_valid && !out_ready.

## Timing
- Latency 1 cycle: beat accepted at edge N is on outputs after edge N (visible cycle N+1) when stage empty.
- Throughput 1 beat/cycle with out_ready held high; in_ready never drops in that case.
- Stall: first stalled cycle still accepts one beat into skid; in_ready falls next cycle; rises cycle after skid drains.
- Order preserved: skid entry always issues before any new input.
- flush: next edge clears out_valid and skid_valid; an input offered in the flush cycle is discarded; in_ready=1 following cycle. flush beats rst? rst has priority; both give same result.
- Reset: out_valid=0, in_ready=0 while rst high, 1 first cycle after; alu_control, shift_amount, data1, data2, dest_reg=0; reg_write=0; illegal=0.
- Sign extension: {16{instr[15]}, instr[15:0]}; zero extension {16'b0, instr[15:0]}.

## Structure
- Package alu_ctrl_pkg: ALU control codes (values above), opcode and funct constants, issue-beat struct {alu_control, shift_amount, data1, data2, dest_reg, reg_write, illegal}.
- Sub-module mips_alu_decode: purely combinational instr/rs/rt -> beat struct; top holds skid, output register and handshake.

## Test plan
- addi $t1,$t0,-5 (0x2109FFFB), rs_data=10 -> next cycle alu_control=0000, data1=10, data2=0xFFFFFFFB, dest_reg=9, reg_write=1.
- sra $t2,$t1,4 (0x00095103), rt_data=0x80000000 -> alu_control=0110, data1=0x80000000, shift_amount=4, dest_reg=10.
- lui $t0,0x1234 (0x3C081234) -> alu_control=0100, data1=0x00001234, shift_amount=16; ori (0x35080001) -> alu_control=0011, data2=0x00000001.
- Stream 4 beats, out_ready=0 at beats 2-3 -> in_ready low one cycle later, all 4 beats out in order, none duplicated, outputs frozen during stall.
- flush with output and skid full plus in_valid=1 -> out_valid=0 next cycle, offered beat never appears; opcode 0x3F -> illegal=1, reg_write=0, data1=data2=0.
- rst asserted mid-stall with skid full -> all outputs 0, out_valid=0 next cycle, in_ready=1 after rst drops.
